// File: rtl/i2c_gpio_expander_n.sv
// I2C slave GPIO expander: N_PORTS x 8-bit ports with input, output,
// polarity and config registers plus a change-of-input interrupt.
module i2c_gpio_expander_n #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h20,
   parameter int         N_PORTS     = 2,
   parameter int         SYNC_STAGES = 2,
   parameter int         FILT_CYCLES = 3
) (
   input  logic                   sclk,
   input  logic                   reset,
   input  logic                   scl_i,
   input  logic                   sda_i,
   output logic                   sda_oe,
   input  logic [8*N_PORTS-1:0]   gpio_i,
   output logic [8*N_PORTS-1:0]   gpio_o,
   output logic [8*N_PORTS-1:0]   gpio_oe,
   output logic                   int_n
);

   localparam int W    = 8 * N_PORTS;
   localparam int NREG = 4 * N_PORTS;
   localparam int PW   = $clog2(NREG);
   localparam int FW   = $clog2(FILT_CYCLES + 1);
   localparam logic [7:0] NREG8 = 8'(NREG);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ADDR      = 4'd1;
   localparam logic [3:0] S_ADDR_ACK  = 4'd2;
   localparam logic [3:0] S_CMD       = 4'd3;
   localparam logic [3:0] S_CMD_ACK   = 4'd4;
   localparam logic [3:0] S_WR_DATA   = 4'd5;
   localparam logic [3:0] S_WR_ACK    = 4'd6;
   localparam logic [3:0] S_RD_DATA   = 4'd7;
   localparam logic [3:0] S_RD_ACK    = 4'd8;
   localparam logic [3:0] S_WAIT_STOP = 4'd9;

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic [W-1:0]           r_gpio_sync [SYNC_STAGES];
   logic [1:0]             r_filt, r_prev;
   logic [FW-1:0]          r_cnt [2];
   logic [3:0]             r_state;
   logic [2:0]             r_bitcnt;
   logic [7:0]             r_shift;
   logic                   r_ack, r_rw, r_snap_ld;
   logic [PW-1:0]          r_ptr;
   logic [W-1:0]           r_out, r_pol, r_cfg, r_snap;

   logic [1:0]    w_raw;
   logic [W-1:0]  w_gpio;
   logic          w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_load;
   logic [7:0]    w_byte, w_rd;
   logic [PW-1:0] w_ptr_nxt;

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      end
   end

   // Pin synchroniser keeps sampling through reset so the snapshot is valid at release.
   always_ff @(posedge sclk) begin
      r_gpio_sync[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++)
         r_gpio_sync[i] <= r_gpio_sync[i-1];
   end

   assign w_raw  = {r_sda_sync[SYNC_STAGES-1], r_scl_sync[SYNC_STAGES-1]};
   assign w_gpio = r_gpio_sync[SYNC_STAGES-1];

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         r_filt <= 2'b11;
         r_prev <= 2'b11;
         r_cnt  <= '{default: '0};
      end else begin
         r_prev <= r_filt;
         for (int i = 0; i < 2; i++) begin
            if (w_raw[i] == r_filt[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == FW'(FILT_CYCLES - 1)) begin
               r_filt[i] <= w_raw[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_scl   = r_filt[0];
   assign w_sda   = r_filt[1];
   assign w_rise  = w_scl & ~r_prev[0];
   assign w_fall  = ~w_scl & r_prev[0];
   assign w_start = w_scl & r_prev[0] & r_prev[1] & ~w_sda;
   assign w_stop  = w_scl & r_prev[0] & ~r_prev[1] & w_sda;
   assign w_byte  = {r_shift[6:0], w_sda};
   assign w_load  = w_fall & r_ack &
                    ((r_state == S_ADDR_ACK && r_rw) || r_state == S_RD_ACK);

   always_comb begin
      w_rd      = '0;
      w_ptr_nxt = r_ptr + 1'b1;
      for (int p = 0; p < N_PORTS; p++) begin
         if (r_ptr == PW'(p))
            w_rd = w_gpio[p*8 +: 8] ^ r_pol[p*8 +: 8];
         if (r_ptr == PW'(N_PORTS + p))
            w_rd = r_out[p*8 +: 8];
         if (r_ptr == PW'(2*N_PORTS + p))
            w_rd = r_pol[p*8 +: 8];
         if (r_ptr == PW'(3*N_PORTS + p))
            w_rd = r_cfg[p*8 +: 8];
      end
      for (int g = 0; g < 4; g++)
         if (r_ptr == PW'(g*N_PORTS + N_PORTS - 1))
            w_ptr_nxt = PW'(g*N_PORTS);
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_bitcnt  <= 3'd7;
         r_shift   <= '0;
         r_ack     <= 1'b0;
         r_rw      <= 1'b0;
         r_ptr     <= '0;
         sda_oe    <= 1'b0;
         r_out     <= '1;
         r_cfg     <= '1;
         r_pol     <= '0;
         r_snap    <= '0;
         r_snap_ld <= 1'b1;
      end else begin
         if (r_snap_ld) begin
            r_snap    <= w_gpio;
            r_snap_ld <= 1'b0;
         end
         if (w_start) begin
            r_state  <= S_ADDR;
            r_bitcnt <= 3'd7;
            r_ack    <= 1'b0;
            sda_oe   <= 1'b0;
         end else if (w_stop) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            sda_oe  <= 1'b0;
         end else if (w_rise) begin
            case (r_state)
               S_ADDR, S_CMD, S_WR_DATA: begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt - 3'd1;
                  r_ack    <= 1'b0;
                  if (r_bitcnt == 3'd0) begin
                     if (r_state == S_ADDR) begin
                        r_rw    <= w_byte[0];
                        r_state <= (w_byte[7:1] == SLAVE_ADDR) ?
                                   S_ADDR_ACK : S_WAIT_STOP;
                     end else if (r_state == S_CMD) begin
                        if (w_byte < NREG8) begin
                           r_ptr   <= w_byte[PW-1:0];
                           r_state <= S_CMD_ACK;
                        end else begin
                           r_state <= S_WAIT_STOP;
                        end
                     end else begin
                        r_state <= S_WR_ACK;
                     end
                  end
               end
               S_RD_DATA: begin
                  r_bitcnt <= r_bitcnt - 3'd1;
                  if (r_bitcnt == 3'd0) begin
                     r_state <= S_RD_ACK;
                     r_ack   <= 1'b0;
                  end
               end
               S_WR_ACK: begin
                  for (int p = 0; p < N_PORTS; p++) begin
                     if (r_ptr == PW'(N_PORTS + p))
                        r_out[p*8 +: 8] <= r_shift;
                     if (r_ptr == PW'(2*N_PORTS + p))
                        r_pol[p*8 +: 8] <= r_shift;
                     if (r_ptr == PW'(3*N_PORTS + p))
                        r_cfg[p*8 +: 8] <= r_shift;
                  end
                  r_ptr <= w_ptr_nxt;
               end
               S_RD_ACK: begin
                  if (w_sda)
                     r_state <= S_WAIT_STOP;
                  else
                     r_ptr <= w_ptr_nxt;
               end
               default: ;
            endcase
         end else if (w_load) begin
            // Byte leaves for the master here; input ports re-arm their snapshot.
            r_shift  <= w_rd;
            sda_oe   <= ~w_rd[7];
            r_bitcnt <= 3'd7;
            r_ack    <= 1'b0;
            r_state  <= S_RD_DATA;
            for (int p = 0; p < N_PORTS; p++)
               if (r_ptr == PW'(p))
                  r_snap[p*8 +: 8] <= w_gpio[p*8 +: 8];
         end else if (w_fall) begin
            case (r_state)
               S_ADDR_ACK, S_CMD_ACK, S_WR_ACK: begin
                  if (!r_ack) begin
                     r_ack  <= 1'b1;
                     sda_oe <= 1'b1;
                  end else begin
                     r_ack    <= 1'b0;
                     sda_oe   <= 1'b0;
                     r_bitcnt <= 3'd7;
                     r_state  <= (r_state == S_ADDR_ACK) ? S_CMD : S_WR_DATA;
                  end
               end
               S_RD_DATA: sda_oe <= ~r_shift[r_bitcnt];
               S_RD_ACK: begin
                  r_ack  <= 1'b1;
                  sda_oe <= 1'b0;
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset)
         int_n <= 1'b1;
      else
         int_n <= ~|((w_gpio ^ r_snap) & r_cfg);
   end

   assign gpio_o  = r_out;
   assign gpio_oe = ~r_cfg;

endmodule

// File: tb/tb_i2c_gpio_expander_n.sv
// Directed bench for i2c_gpio_expander_n with a transaction-level
// register model checked against the DUT outputs every idle cycle.
module tb_i2c_gpio_expander_n;

   localparam int N = 2;
   localparam int W = 16;
   localparam int SYNC = 2;
   localparam int H = 10;
   localparam logic [6:0] SA = 7'h20;

   logic         sclk = 1'b0;
   logic         reset = 1'b1;
   logic         scl_drv = 1'b1;
   logic         sda_drv = 1'b1;
   logic         scl_i, sda_i, sda_oe, int_n;
   logic [W-1:0] gpio_i = '0;
   logic [W-1:0] gpio_o, gpio_oe;

   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;
   logic glitch_en = 1'b0;
   logic watch_oe = 1'b0;
   logic saw_oe = 1'b0;

   logic [W-1:0] m_out, m_pol, m_cfg, m_snap;
   int           m_ptr;

   assign scl_i = scl_drv;
   assign sda_i = sda_drv & ~sda_oe;

   i2c_gpio_expander_n #(
      .SLAVE_ADDR(SA), .N_PORTS(N), .SYNC_STAGES(SYNC), .FILT_CYCLES(3)
   ) dut (
      .sclk(sclk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i),
      .sda_oe(sda_oe), .gpio_i(gpio_i), .gpio_o(gpio_o),
      .gpio_oe(gpio_oe), .int_n(int_n)
   );

   always #5 sclk = ~sclk;

   initial begin
      #5ms;
      $display("FAIL timeout");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic m_intn();
      return ~|((gpio_i ^ m_snap) & m_cfg);
   endfunction

   function automatic logic [7:0] m_rd(input int idx);
      int g = idx / N;
      int p = idx % N;
      case (g)
         0: return gpio_i[p*8 +: 8] ^ m_pol[p*8 +: 8];
         1: return m_out[p*8 +: 8];
         2: return m_pol[p*8 +: 8];
         default: return m_cfg[p*8 +: 8];
      endcase
   endfunction

   task automatic m_wr(input int idx, input logic [7:0] d);
      int g = idx / N;
      int p = idx % N;
      case (g)
         1: m_out[p*8 +: 8] = d;
         2: m_pol[p*8 +: 8] = d;
         3: m_cfg[p*8 +: 8] = d;
         default: ;
      endcase
   endtask

   function automatic int m_adv(input int idx);
      return (idx / N) * N + (idx % N + 1) % N;
   endfunction

   task automatic m_reset();
      m_out  = '1;
      m_cfg  = '1;
      m_pol  = '0;
      m_snap = gpio_i;
      m_ptr  = 0;
   endtask

   always @(negedge sclk) begin
      if (chk_en) begin
         checks++;
         if (gpio_o !== m_out || gpio_oe !== ~m_cfg || int_n !== m_intn()) begin
            errors++;
            $display("FAIL cmp t=%0t gpio_o %h exp %h gpio_oe %h exp %h int_n %b exp %b",
                     $time, gpio_o, m_out, gpio_oe, ~m_cfg, int_n, m_intn());
         end
      end
   end

   always @(posedge sclk)
      if (watch_oe && sda_oe) saw_oe = 1'b1;

   task automatic tick(input int n);
      repeat (n) @(posedge sclk);
      #1;
   endtask

   task automatic bit_wr(input logic b);
      tick(H/2);
      sda_drv = b;
      if (glitch_en) begin
         tick(2); scl_drv = 1'b1; tick(1); scl_drv = 1'b0; tick(H/2 - 3);
      end else begin
         tick(H/2);
      end
      scl_drv = 1'b1;
      tick(H);
      scl_drv = 1'b0;
   endtask

   task automatic bit_rd(output logic b);
      tick(H/2);
      sda_drv = 1'b1;
      tick(H/2);
      scl_drv = 1'b1;
      tick(H - 1);
      b = sda_i;
      tick(1);
      scl_drv = 1'b0;
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_wr(d[i]);
      bit_rd(r);
      ack = ~r;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) bit_rd(d[i]);
      bit_wr(~mack);
   endtask

   task automatic i2c_start();
      tick(H/2); sda_drv = 1'b1;
      tick(H/2); scl_drv = 1'b1;
      tick(H);   sda_drv = 1'b0;
      tick(H);   scl_drv = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(H/2); sda_drv = 1'b0;
      tick(H/2); scl_drv = 1'b1;
      tick(H);   sda_drv = 1'b1;
      tick(H);
   endtask

   task automatic txn_write(input logic [7:0] cmd, input int n,
                            input logic [31:0] data);
      logic a;
      chk_en = 1'b0;
      i2c_start();
      wr_byte({SA, 1'b0}, a);
      chk("wr addr ack", a, 1);
      wr_byte(cmd, a);
      chk("wr cmd ack", a, cmd < 4*N);
      if (cmd < 4*N) begin
         m_ptr = cmd;
         for (int i = 0; i < n; i++) begin
            wr_byte(data[8*i +: 8], a);
            chk("wr data ack", a, 1);
            m_wr(m_ptr, data[8*i +: 8]);
            m_ptr = m_adv(m_ptr);
         end
      end
      i2c_stop();
      tick(4);
      chk_en = 1'b1;
   endtask

   task automatic txn_read(input logic use_cmd, input logic [7:0] cmd,
                           input int n, output logic [31:0] got);
      logic       a;
      logic [7:0] d, e;
      chk_en = 1'b0;
      got = '0;
      i2c_start();
      if (use_cmd) begin
         wr_byte({SA, 1'b0}, a);
         chk("rd waddr ack", a, 1);
         wr_byte(cmd, a);
         chk("rd cmd ack", a, 1);
         m_ptr = cmd;
         i2c_start();
      end
      wr_byte({SA, 1'b1}, a);
      chk("rd addr ack", a, 1);
      for (int i = 0; i < n; i++) begin
         e = m_rd(m_ptr);
         if (m_ptr < N) m_snap[m_ptr*8 +: 8] = gpio_i[m_ptr*8 +: 8];
         rd_byte(i < n - 1, d);
         chk("rd data", d, e);
         got[8*i +: 8] = d;
         if (i < n - 1) m_ptr = m_adv(m_ptr);
      end
      i2c_stop();
      tick(4);
      chk_en = 1'b1;
   endtask

   initial begin
      logic [31:0] got;
      logic        a;
      int          k;
      tick(5);
      chk("rst sda_oe", sda_oe, 0);
      chk("rst int_n", int_n, 1);
      chk("rst gpio_o", gpio_o, 16'hFFFF);
      chk("rst gpio_oe", gpio_oe, 16'h0000);
      reset = 1'b0;
      m_reset();
      tick(5);
      chk_en = 1'b1;
      tick(5);

      txn_write(8'h02, 2, 32'h3CA5);
      chk("wr gpio_o", gpio_o, 16'h3CA5);
      txn_write(8'h06, 2, 32'h0000);
      chk("cfg gpio_oe", gpio_oe, 16'hFFFF);
      txn_write(8'h06, 2, 32'hFFFF);
      txn_write(8'h02, 3, 32'h332211);
      chk("wrap gpio_o", gpio_o, 16'h2233);
      txn_read(1'b0, 8'h00, 1, got);
      chk("ptr retained", got, 32'h22);

      chk_en = 1'b0;
      gpio_i = 16'h1234;
      tick(8);
      chk_en = 1'b1;
      chk("int on change", int_n, 0);
      txn_read(1'b1, 8'h00, 2, got);
      chk("rd 1234", got, 32'h1234);
      chk("int after rd", int_n, 1);
      txn_read(1'b0, 8'h00, 1, got);
      chk("rd ptr inc", got, 32'h12);

      txn_write(8'h04, 1, 32'hFF);
      chk_en = 1'b0;
      gpio_i = 16'h120F;
      tick(8);
      chk_en = 1'b1;
      txn_read(1'b1, 8'h00, 1, got);
      chk("pol rd", got, 32'hF0);

      chk_en = 1'b0;
      saw_oe = 1'b0;
      watch_oe = 1'b1;
      i2c_start();
      wr_byte(8'h42, a);
      chk("mis addr ack", a, 0);
      wr_byte(8'h00, a);
      wr_byte(8'hFF, a);
      watch_oe = 1'b0;
      i2c_stop();
      chk("mis no drive", saw_oe, 0);
      chk_en = 1'b1;
      txn_write(8'h08, 0, 32'h0);

      chk("int idle", int_n, 1);
      chk_en = 1'b0;
      gpio_i[9] = ~gpio_i[9];
      k = 0;
      while (int_n !== 1'b0 && k < SYNC + 2) begin
         tick(1);
         k++;
      end
      chk("int latency", int_n, 0);
      tick(5);
      chk_en = 1'b1;
      txn_read(1'b1, 8'h01, 1, got);
      chk("rd port1", got, 32'h10);
      chk("int cleared", int_n, 1);

      glitch_en = 1'b1;
      txn_write(8'h03, 1, 32'h5A);
      glitch_en = 1'b0;
      chk("glitch wr", gpio_o, 16'h5A33);

      chk_en = 1'b0;
      i2c_start();
      wr_byte({SA, 1'b1}, a);
      chk("rd addr ack2", a, 1);
      k = 0;
      while (sda_oe !== 1'b1 && k < 20) begin
         tick(1);
         k++;
      end
      chk("rd drives", sda_oe, 1);
      reset = 1'b1;
      #1;
      chk("rst mid sda_oe", sda_oe, 0);
      chk("rst mid gpio_o", gpio_o, 16'hFFFF);
      chk("rst mid gpio_oe", gpio_oe, 16'h0000);
      tick(3);
      sda_drv = 1'b1;
      scl_drv = 1'b1;
      tick(2);
      reset = 1'b0;
      m_reset();
      tick(10);
      chk_en = 1'b1;
      txn_write(8'h02, 1, 32'h01);
      chk("post rst wr", gpio_o, 16'hFF01);
      tick(5);
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
